seg_scan_driver: RTL



---
 rtl/seg_scan_driver.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexes two 7-segment patterns (amount digit 0,
//               status digit 1) onto one shared segment bus. One-hot digit
//               enables are used, with a blanking guard at the start of every
//               slot so that no digit ghosts onto its neighbour. Both
//               patterns are captured once per frame so that a digit never
//               shows a half-updated value. The status LEDs pass through
//               one register stage.
//               Optional feature macro: SEG_BLINK_EN. When it is defined,
//               digit 1 blinks at a frame-counted rate while the LED vector
//               captured at frame start reads RETURN_CHANGE (4'b1100).
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] amount_display,
  input  logic [7:0] status_display,
  input  logic [3:0] led_indicators,
  output logic [7:0] seg_out,
  output logic [1:0] digit_en,
  output logic [3:0] led_out
);

  localparam int             C_CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(SCAN_DIV - 1);
  localparam logic [C_CNT_W-1:0] C_BLANK   = C_CNT_W'(BLANK_CYCLES);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);

  // Slot position and digit index
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               idx_q, idx_d;

  // Per-frame pattern snapshots
  logic [7:0] snap0_q, snap0_d;
  logic [7:0] snap1_q, snap1_d;

  // Output registers
  logic [7:0] seg_q, seg_d;
  logic [1:0] en_q, en_d;
  logic [3:0] led_q, led_d;

  logic slot_wrap;
  logic frame_start;
  logic blink_off;

  assign slot_wrap   = (cnt_q == C_CNT_MAX);
  assign frame_start = (cnt_q == '0) && !idx_q;

  // Slot counter advances every cycle; the digit index flips at slot wrap
  always_comb begin
    cnt_d = cnt_q + C_CNT_ONE;
    idx_d = idx_q;
    if (slot_wrap) begin
      cnt_d = '0;
      idx_d = ~idx_q;
    end
  end

  // Both patterns are sampled together at frame start only (anti-tear)
  always_comb begin
    snap0_d = snap0_q;
    snap1_d = snap1_q;
    if (frame_start) begin
      snap0_d = amount_display;
      snap1_d = status_display;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int                 C_FRM_W         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [C_FRM_W-1:0] C_FRM_MAX       = C_FRM_W'(BLINK_FRAMES - 1);
  localparam logic [C_FRM_W-1:0] C_FRM_ONE       = C_FRM_W'(1);
  localparam logic [3:0]         C_RETURN_CHANGE = 4'b1100;

  logic [C_FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               phase_q, phase_d;
  logic [3:0]         led_snap_q, led_snap_d;

  // Frame counter ticks when the status slot ends; the phase flips every
  // BLINK_FRAMES completed frames. The LED vector is latched with the patterns.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    led_snap_d  = led_snap_q;
    if (frame_start) begin
      led_snap_d = led_indicators;
    end
    if (slot_wrap && idx_q) begin
      if (frame_cnt_q == C_FRM_MAX) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + C_FRM_ONE;
      end
    end
  end

  // Blink state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
      led_snap_q  <= 4'b0000;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
      led_snap_q  <= led_snap_d;
    end
  end

  assign blink_off = phase_q && (led_snap_q == C_RETURN_CHANGE);
`else
  localparam int c_unused_blink_frames = BLINK_FRAMES;
  assign blink_off = 1'b0;
`endif

  // Output decode: blank during the guard window, else the active digit
  always_comb begin
    seg_d = 8'h00;
    en_d  = 2'b00;
    led_d = led_indicators;
    if (cnt_q >= C_BLANK) begin
      if (!idx_q) begin
        en_d  = 2'b01;
        seg_d = snap0_q;
      end else if (!blink_off) begin
        en_d  = 2'b10;
        seg_d = snap1_q;
      end
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= 1'b0;
      snap0_q <= 8'h00;
      snap1_q <= 8'h00;
      seg_q   <= 8'h00;
      en_q    <= 2'b00;
      led_q   <= 4'b0000;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap0_q <= snap0_d;
      snap1_q <= snap1_d;
      seg_q   <= seg_d;
      en_q    <= en_d;
      led_q   <= led_d;
    end
  end

  assign seg_out  = seg_q;
  assign digit_en = en_q;
  assign led_out  = led_q;

endmodule
`default_nettype wire
